// File: rtl/write_through_buffer.sv
// Write-through buffer between the cache write path and the AXI write channel.
// Small FIFO of word writes that can merge a new write into its newest entry.
module write_through_buffer #(
  parameter int FE_ADDR_W = 32,
  parameter int FE_DATA_W = 32,
  parameter int FE_NBYTES = FE_DATA_W / 8,
  parameter int FE_BYTE_W = $clog2(FE_NBYTES),
  parameter int DEPTH_W   = 2,
  parameter int MERGE_EN  = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_valid,
  input  logic [FE_ADDR_W-FE_BYTE_W-1:0] wr_addr,
  input  logic [FE_DATA_W-1:0]           wr_wdata,
  input  logic [FE_NBYTES-1:0]           wr_wstrb,
  output logic                           wr_ready,
  output logic                           mem_valid,
  output logic [FE_ADDR_W-FE_BYTE_W-1:0] mem_addr,
  output logic [FE_DATA_W-1:0]           mem_wdata,
  output logic [FE_NBYTES-1:0]           mem_wstrb,
  input  logic                           mem_ready,
  output logic                           buf_empty,
  output logic                           buf_full,
  output logic [DEPTH_W:0]               buf_level
);

  localparam int AW    = FE_ADDR_W - FE_BYTE_W;
  localparam int DEPTH = 2 ** DEPTH_W;

  localparam logic [DEPTH_W:0]   LVL_ONE  = (DEPTH_W + 1)'(1);
  localparam logic [DEPTH_W:0]   LVL_TWO  = (DEPTH_W + 1)'(2);
  localparam logic [DEPTH_W:0]   LVL_FULL = {1'b1, {DEPTH_W{1'b0}}};
  localparam logic [DEPTH_W-1:0] PTR_ONE  = DEPTH_W'(1);

  logic [AW-1:0]        addr_q [DEPTH];
  logic [FE_DATA_W-1:0] data_q [DEPTH];
  logic [FE_NBYTES-1:0] strb_q [DEPTH];

  logic [DEPTH_W-1:0] rd_ptr;
  logic [DEPTH_W-1:0] wr_ptr;
  logic [DEPTH_W-1:0] newest_ptr;
  logic [DEPTH_W:0]   level;

  logic full;
  logic merge_hit;
  logic push;
  logic pop;

  // Overwrite only the strobed bytes of an existing entry.
  function automatic logic [FE_DATA_W-1:0] merge_bytes(
    input logic [FE_DATA_W-1:0] old_data,
    input logic [FE_DATA_W-1:0] new_data,
    input logic [FE_NBYTES-1:0] strb
  );
    logic [FE_DATA_W-1:0] res;
    res = old_data;
    for (int b = 0; b < FE_NBYTES; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_data[b*8 +: 8];
    end
    return res;
  endfunction

  assign newest_ptr = wr_ptr - PTR_ONE;
  assign full       = (level == LVL_FULL);

  // Merging needs at least two entries so the head stays untouched.
  assign merge_hit = (MERGE_EN != 0) && wr_valid && (level >= LVL_TWO) &&
                     (wr_addr == addr_q[newest_ptr]);
  assign push      = wr_valid && !merge_hit && !full;
  assign pop       = mem_valid && mem_ready;

  assign wr_ready  = merge_hit || !full;

  assign mem_valid = (level != '0);
  assign mem_addr  = addr_q[rd_ptr];
  assign mem_wdata = data_q[rd_ptr];
  assign mem_wstrb = strb_q[rd_ptr];

  assign buf_empty = (level == '0);
  assign buf_full  = full;
  assign buf_level = level;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        strb_q[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_q[wr_ptr] <= wr_addr;
        data_q[wr_ptr] <= wr_wdata;
        strb_q[wr_ptr] <= wr_wstrb;
        wr_ptr         <= wr_ptr + PTR_ONE;
      end
      if (merge_hit) begin
        data_q[newest_ptr] <= merge_bytes(data_q[newest_ptr], wr_wdata, wr_wstrb);
        strb_q[newest_ptr] <= strb_q[newest_ptr] | wr_wstrb;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      level <= level + LVL_ONE;
      else if (pop && !push) level <= level - LVL_ONE;
    end
  end

endmodule

// File: tb/tb_write_through_buffer.sv
// Scoreboard bench for write_through_buffer: expected head entries are queued at
// stimulus time and popped by monitors whenever the DUT completes a handshake.
module tb_write_through_buffer;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        wr_valid = 1'b0;
  logic [29:0] wr_addr = '0;
  logic [31:0] wr_wdata = '0;
  logic [3:0]  wr_wstrb = '0;
  logic        wr_ready;
  logic        mem_valid;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic        buf_empty;
  logic        buf_full;
  logic [2:0]  buf_level;

  logic        nm_wr_valid = 1'b0;
  logic [29:0] nm_wr_addr = '0;
  logic [31:0] nm_wr_wdata = '0;
  logic [3:0]  nm_wr_wstrb = '0;
  logic        nm_wr_ready;
  logic        nm_mem_valid;
  logic [29:0] nm_mem_addr;
  logic [31:0] nm_mem_wdata;
  logic [3:0]  nm_mem_wstrb;
  logic        nm_mem_ready = 1'b0;
  logic        nm_buf_empty;
  logic        nm_buf_full;
  logic [2:0]  nm_buf_level;

  int n_cmp = 0;
  int n_bad = 0;
  ent_t exp_q[$];
  ent_t nm_q[$];

  always #5 clk = ~clk;

  write_through_buffer #(.DEPTH_W(2), .MERGE_EN(1)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_wdata(wr_wdata), .wr_wstrb(wr_wstrb),
    .wr_ready(wr_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready),
    .buf_empty(buf_empty), .buf_full(buf_full), .buf_level(buf_level)
  );

  write_through_buffer #(.DEPTH_W(2), .MERGE_EN(0)) dut_nm (
    .clk(clk), .reset(reset),
    .wr_valid(nm_wr_valid), .wr_addr(nm_wr_addr), .wr_wdata(nm_wr_wdata), .wr_wstrb(nm_wr_wstrb),
    .wr_ready(nm_wr_ready),
    .mem_valid(nm_mem_valid), .mem_addr(nm_mem_addr), .mem_wdata(nm_mem_wdata),
    .mem_wstrb(nm_mem_wstrb), .mem_ready(nm_mem_ready),
    .buf_empty(nm_buf_empty), .buf_full(nm_buf_full), .buf_level(nm_buf_level)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_valid = 1'b1; wr_addr = a; wr_wdata = d; wr_wstrb = s;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    mem_ready = 1'b1;
    repeat (n) step();
    mem_ready = 1'b0;
  endtask

  // Head monitors: sampled on the falling edge, ahead of the popping edge.
  always @(negedge clk) begin
    if (!reset && mem_valid && mem_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL pop_unexpected: got addr 0x%0h expected no entry", mem_addr);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("pop_addr", 64'(mem_addr), 64'(e.a));
        chk("pop_data", 64'(mem_wdata), 64'(e.d));
        chk("pop_strb", 64'(mem_wstrb), 64'(e.s));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && nm_mem_valid && nm_mem_ready) begin
      if (nm_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL nm_pop_unexpected: got addr 0x%0h expected no entry", nm_mem_addr);
      end else begin
        ent_t e;
        e = nm_q.pop_front();
        chk("nm_pop_addr", 64'(nm_mem_addr), 64'(e.a));
        chk("nm_pop_data", 64'(nm_mem_wdata), 64'(e.d));
        chk("nm_pop_strb", 64'(nm_mem_wstrb), 64'(e.s));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    reset = 1'b0;
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_mem_addr",  64'(mem_addr),  64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    chk("rst_empty",     64'(buf_empty), 64'd1);
    chk("rst_full",      64'(buf_full),  64'd0);
    chk("rst_level",     64'(buf_level), 64'd0);
    chk("rst_wr_ready",  64'(wr_ready),  64'd1);

    // Single push then pop
    exp_q.push_back('{30'h100, 32'h11111111, 4'hF});
    wr(30'h100, 32'h11111111, 4'hF);
    chk("t1_valid", 64'(mem_valid), 64'd1);
    chk("t1_addr",  64'(mem_addr),  64'h100);
    chk("t1_level", 64'(buf_level), 64'd1);
    drain(1);
    chk("t1_valid_after_pop", 64'(mem_valid), 64'd0);
    chk("t1_empty", 64'(buf_empty), 64'd1);

    // Fill to full, reject a fifth distinct write, drain in order
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{30'h200 + 30'(i), 32'hA0A0A0A0 + 32'(i), 4'hF});
      wr(30'h200 + 30'(i), 32'hA0A0A0A0 + 32'(i), 4'hF);
    end
    chk("t2_full",  64'(buf_full),  64'd1);
    chk("t2_level", 64'(buf_level), 64'd4);
    wr_valid = 1'b1; wr_addr = 30'h2FF; wr_wdata = 32'hDEADBEEF; wr_wstrb = 4'hF;
    #1;
    chk("t2_wr_ready_full", 64'(wr_ready), 64'd0);
    step();
    wr_valid = 1'b0;
    chk("t2_level_after_reject", 64'(buf_level), 64'd4);
    drain(4);
    chk("t2_empty", 64'(buf_empty), 64'd1);

    // Merge into newest non-head entry
    exp_q.push_back('{30'h10, 32'h01010101, 4'hF});
    wr(30'h10, 32'h01010101, 4'hF);
    wr(30'h20, 32'h11223344, 4'h4);
    exp_q.push_back('{30'h20, 32'h1122CCDD, 4'h7});
    wr_valid = 1'b1; wr_addr = 30'h20; wr_wdata = 32'hAABBCCDD; wr_wstrb = 4'h3;
    #1;
    chk("t3_wr_ready_merge", 64'(wr_ready), 64'd1);
    step();
    wr_valid = 1'b0;
    chk("t3_level", 64'(buf_level), 64'd2);
    drain(2);

    // Level 1: same address as head is pushed, head untouched
    exp_q.push_back('{30'h30, 32'h30303030, 4'h1});
    exp_q.push_back('{30'h30, 32'h31313131, 4'h2});
    wr(30'h30, 32'h30303030, 4'h1);
    wr(30'h30, 32'h31313131, 4'h2);
    chk("t4_level", 64'(buf_level), 64'd2);
    chk("t4_head_addr", 64'(mem_addr),  64'h30);
    chk("t4_head_data", 64'(mem_wdata), 64'h30303030);
    chk("t4_head_strb", 64'(mem_wstrb), 64'h1);
    drain(2);

    // Full with newest 0x40: merge while popping, then reject distinct while popping
    exp_q.push_back('{30'h41, 32'h41414141, 4'hF});
    exp_q.push_back('{30'h42, 32'h42424242, 4'hF});
    exp_q.push_back('{30'h43, 32'h43434343, 4'hF});
    exp_q.push_back('{30'h40, 32'h0000AB40, 4'h3});
    wr(30'h41, 32'h41414141, 4'hF);
    wr(30'h42, 32'h42424242, 4'hF);
    wr(30'h43, 32'h43434343, 4'hF);
    wr(30'h40, 32'h00000040, 4'h1);
    mem_ready = 1'b1;
    wr_valid = 1'b1; wr_addr = 30'h40; wr_wdata = 32'h0000AB00; wr_wstrb = 4'h2;
    #1;
    chk("t5_wr_ready_merge_full", 64'(wr_ready), 64'd1);
    step();
    wr_valid = 1'b0; mem_ready = 1'b0;
    chk("t5_level_merge_pop", 64'(buf_level), 64'd3);
    exp_q.push_back('{30'h50, 32'h50505050, 4'hF});
    wr(30'h50, 32'h50505050, 4'hF);
    chk("t5_full_again", 64'(buf_full), 64'd1);
    mem_ready = 1'b1;
    wr_valid = 1'b1; wr_addr = 30'h60; wr_wdata = 32'h60606060; wr_wstrb = 4'hF;
    #1;
    chk("t5_wr_ready_full_pop", 64'(wr_ready), 64'd0);
    step();
    wr_valid = 1'b0; mem_ready = 1'b0;
    chk("t5_level_after_pop", 64'(buf_level), 64'd3);
    drain(3);
    chk("t5_empty", 64'(buf_empty), 64'd1);

    // Merging disabled: same address twice makes two entries
    nm_q.push_back('{30'h80, 32'h00000001, 4'hF});
    nm_q.push_back('{30'h80, 32'h00000002, 4'h1});
    nm_wr_valid = 1'b1; nm_wr_addr = 30'h80; nm_wr_wdata = 32'h1; nm_wr_wstrb = 4'hF;
    step();
    nm_wr_wdata = 32'h2; nm_wr_wstrb = 4'h1;
    step();
    nm_wr_valid = 1'b0;
    chk("nm_level", 64'(nm_buf_level), 64'd2);
    nm_mem_ready = 1'b1;
    step(); step();
    nm_mem_ready = 1'b0;
    chk("nm_empty", 64'(nm_buf_empty), 64'd1);

    // Reset mid-operation discards entries
    wr(30'h70, 32'h70707070, 4'hF);
    wr(30'h71, 32'h71717171, 4'hF);
    wr(30'h72, 32'h72727272, 4'hF);
    chk("t6_level_before", 64'(buf_level), 64'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_level",     64'(buf_level), 64'd0);
    chk("t6_mem_valid", 64'(mem_valid), 64'd0);
    chk("t6_mem_addr",  64'(mem_addr),  64'd0);
    chk("t6_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("t6_mem_wstrb", 64'(mem_wstrb), 64'd0);
    chk("t6_empty",     64'(buf_empty), 64'd1);

    step();
    chk("scoreboard_leftover",    64'(exp_q.size()), 64'd0);
    chk("nm_scoreboard_leftover", 64'(nm_q.size()),  64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/write_through_buffer.md
Name: write_through_buffer

Overview:
- Write FIFO between the cache front-end write path and the AXI write channel.
- Accepts word writes of address, data and byte strobes from the cache controller and presents the oldest entry downstream.
- Holds that entry stable until the downstream block signals completion.
- Optionally merges a new write into the newest queued entry when the word addresses match, which cuts AXI traffic.
- Exposes empty/full/level so the cache controller can stall reads on read-after-write hazards.

Parameters:
- FE_ADDR_W, 32, front-end byte-address width.
- FE_DATA_W, 32, front-end data width.
- FE_NBYTES, FE_DATA_W/8, number of byte strobes.
- FE_BYTE_W, $clog2(FE_NBYTES), byte-offset bits dropped from the address.
- DEPTH_W, 2, log2 of entry count; depth = 2**DEPTH_W, minimum 1.
- MERGE_EN, 1, 1 enables write merging into the newest non-head entry; 0 disables it.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  front-end write request.
- wr_addr  in  FE_ADDR_W-FE_BYTE_W  word address, [FE_ADDR_W-1:FE_BYTE_W].
- wr_wdata  in  FE_DATA_W  write data.
- wr_wstrb  in  FE_NBYTES  byte strobes.
- wr_ready  out  1  request accepted this cycle (push or merge).
- mem_valid  out  1  head entry available.
- mem_addr  out  FE_ADDR_W-FE_BYTE_W  head word address.
- mem_wdata  out  FE_DATA_W  head data.
- mem_wstrb  out  FE_NBYTES  head strobes.
- mem_ready  in  1  downstream finished writing the head; pops it.
- buf_empty  out  1  level == 0.
- buf_full  out  1  level == depth.
- buf_level  out  DEPTH_W+1  number of valid entries.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. All state updates on posedge clk.
- State: entry array addr/data/strb[depth]; rd_ptr and wr_ptr of DEPTH_W bits; level counter of DEPTH_W+1 bits.
- Pointers wrap modulo depth naturally. No separate wrap bit is used; full/empty are derived from level.
- Reset: rd_ptr=0, wr_ptr=0, level=0, all entry fields cleared to 0.
  - Outputs after reset: mem_valid=0, mem_addr/mem_wdata/mem_wstrb=0, buf_empty=1, buf_full=0, buf_level=0.
  - wr_ready = 1 after reset (combinational, see below).
- Reset mid-operation discards all entries with no downstream indication. Downstream must be reset with the buffer.
- Head outputs are combinational reads of entry[rd_ptr]. mem_valid = (level != 0).
- Head stability: while mem_valid=1 and mem_ready=0, mem_addr/mem_wdata/mem_wstrb hold constant. The head is never modified.
- Pop: mem_valid & mem_ready → rd_ptr+1, level-1. mem_ready while empty is ignored.
- merge_hit = MERGE_EN & wr_valid & (level >= 2) & (wr_addr == entry[wr_ptr-1].addr).
  - Only the newest entry is compared.
  - Level 1 never merges, because the newest entry is then the head.
- Merge: for each byte b with wr_wstrb[b]=1, entry[wr_ptr-1].data byte b ← wr_wdata byte b.
  - strb ← strb | wr_wstrb.
  - Pointers and level are unchanged.
- Push: wr_valid & ~merge_hit & ~full → entry[wr_ptr] ← {wr_addr, wr_wdata, wr_wstrb}, wr_ptr+1, level+1.
  - wr_wstrb=0 is still pushed.
- wr_ready = merge_hit | ~full. It is combinational and valid in the same cycle as wr_valid.
- A full buffer accepts only merges. A push is not allowed even if a pop happens in the same cycle (no full-bypass).
- Simultaneous push and pop: level is unchanged and both pointers advance.
- Simultaneous merge and pop at level 2: merge into entry rd_ptr+1 is legal. Level becomes 1.
- Empty buffer with push: mem_valid rises the cycle after the accepting edge. Latency is 1 cycle and there is no combinational bypass.
- Data order: entries leave in strict acceptance order. A merge does not reorder.
- buf_empty/buf_full/buf_level are registered-state derived and change only after clock edges.

Test Plan:
- Reset, then push A=0x100/D=0x11111111/S=0xF → next cycle mem_valid=1, mem_addr=0x100, level=1; mem_ready pulse → mem_valid=0, buf_empty=1.
- Push 4 distinct addresses with mem_ready=0 → buf_full=1, level=4, wr_ready=0 for a 5th distinct address; that write is not stored. Then 4 pops return entries in order.
- Queue 0x10 (head) and 0x20; write 0x20 D=0xAABBCCDD S=0x3 onto entry 0x20 holding D=0x11223344 S=0x4 → level stays 2, entry becomes D=0x1122CCDD S=0x7.
- Level=1 with head 0x30; write 0x30 → pushed as a new entry (level=2). Head outputs unchanged throughout.
- Full buffer with newest 0x40; write 0x40 with mem_ready=1 in the same cycle → wr_ready=1, merge applied, level 3. A same-cycle distinct address while full and popping → wr_ready=0.
- MERGE_EN=0: two back-to-back writes to the same address → two entries, level=2.
- Reset asserted with level=3 → next cycle level=0, mem_valid=0, outputs 0.
